// File: rtl/motor_pkg.sv
// Shared definitions for the stepper motor channel: FSM encoding, RAM word map
// for the motor registers, and default step timing.
package motor_pkg;

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_DIR_SETUP = 2'd1,
      ST_STEP_HI   = 2'd2,
      ST_STEP_LO   = 2'd3
   } motor_state_t;

   // RAM word indices: chip motor at 9, motor positions 1-4 at 10..13
   localparam int MOTOR_CHIP_IDX     = 9;
   localparam int MOTOR_POS_IDX0     = 10;
   localparam int MOTOR_POS_IDX_LAST = 13;
   localparam int MOTOR_COUNT        = MOTOR_POS_IDX_LAST - MOTOR_POS_IDX0 + 1;

   localparam int DEF_POS_WIDTH   = 32;
   localparam int DEF_CNT_WIDTH   = 20;
   localparam int DEF_STEP_PERIOD = 50000;
   localparam int DEF_PULSE_WIDTH = 500;
   localparam int DEF_DIR_SETUP   = 250;

   function automatic int motor_pos_idx(input int motor);
      return MOTOR_POS_IDX0 + motor;
   endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter pacing each FSM state; done is high once the count
// reaches zero and stays there until the next load.
module step_timer
   import motor_pkg::*;
#(
   parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] value,
   output logic                 done
);

   logic [CNT_WIDTH-1:0] count;

   // Count register: load wins, otherwise decrement and hold at zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (count != '0) begin
         count <= count - CNT_WIDTH'(1);
      end else begin
         count <= count;
      end
   end

   assign done = (count == '0);

endmodule

// File: rtl/stepper_position_ctrl.sv
// Per-motor stepper driver: walks cur_pos toward target_pos one STEP pulse at a
// time, with DIR settled before the first rise of each run.
module stepper_position_ctrl
   import motor_pkg::*;
#(
   parameter int POS_WIDTH   = DEF_POS_WIDTH,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
   parameter int STEP_PERIOD = DEF_STEP_PERIOD,
   parameter int PULSE_WIDTH = DEF_PULSE_WIDTH,
   parameter int DIR_SETUP   = DEF_DIR_SETUP
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        enable,
   input  logic signed [POS_WIDTH-1:0] target_pos,
   input  logic                        zero_pos,
   output logic                        step,
   output logic                        dir,
   output logic                        busy,
   output logic                        at_target,
   output logic signed [POS_WIDTH-1:0] cur_pos
);

   // The timer is loaded with N-1 on entry so each state lasts exactly N cycles
   localparam logic [CNT_WIDTH-1:0] SETUP_LOAD = CNT_WIDTH'(DIR_SETUP - 1);
   localparam logic [CNT_WIDTH-1:0] HI_LOAD    = CNT_WIDTH'(PULSE_WIDTH - 1);
   localparam logic [CNT_WIDTH-1:0] LO_LOAD    = CNT_WIDTH'(STEP_PERIOD - PULSE_WIDTH - 1);

   motor_state_t                 state;
   motor_state_t                 next_state;
   logic                         next_dir;
   logic signed [POS_WIDTH-1:0]  next_pos;
   logic                         tmr_load;
   logic [CNT_WIDTH-1:0]         tmr_value;
   logic                         tmr_done;
   logic                         want_up;
   logic                         at_pos;

   assign want_up = (target_pos > cur_pos);
   assign at_pos  = (target_pos == cur_pos);

   step_timer #(
      .CNT_WIDTH (CNT_WIDTH)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (tmr_load),
      .value (tmr_value),
      .done  (tmr_done)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state, direction, position and timer-load decode
   always_comb begin
      next_state = state;
      next_dir   = dir;
      next_pos   = cur_pos;
      tmr_load   = 1'b0;
      tmr_value  = SETUP_LOAD;
      case (state)
         ST_IDLE: begin
            // A zero request takes the cycle; motion is judged on the next one
            if (zero_pos) begin
               next_pos = '0;
            end else if (enable && !at_pos) begin
               next_state = ST_DIR_SETUP;
               next_dir   = want_up;
               tmr_load   = 1'b1;
               tmr_value  = SETUP_LOAD;
            end else begin
               next_state = ST_IDLE;
            end
         end
         ST_DIR_SETUP: begin
            if (!enable) begin
               next_state = ST_IDLE;
            end else if (tmr_done) begin
               next_state = ST_STEP_HI;
               tmr_load   = 1'b1;
               tmr_value  = HI_LOAD;
            end else begin
               next_state = ST_DIR_SETUP;
            end
         end
         ST_STEP_HI: begin
            if (tmr_done) begin
               next_state = ST_STEP_LO;
               tmr_load   = 1'b1;
               tmr_value  = LO_LOAD;
               next_pos   = dir ? (cur_pos + POS_WIDTH'(1)) : (cur_pos - POS_WIDTH'(1));
            end else begin
               next_state = ST_STEP_HI;
            end
         end
         ST_STEP_LO: begin
            // Target and enable are only re-read once the full period has elapsed
            if (!tmr_done) begin
               next_state = ST_STEP_LO;
            end else if (!enable || at_pos) begin
               next_state = ST_IDLE;
            end else if (want_up == dir) begin
               next_state = ST_STEP_HI;
               tmr_load   = 1'b1;
               tmr_value  = HI_LOAD;
            end else begin
               next_state = ST_DIR_SETUP;
               next_dir   = want_up;
               tmr_load   = 1'b1;
               tmr_value  = SETUP_LOAD;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
   end

   // Registered pins and status, taken from next-state values to line up with the state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step      <= 1'b0;
         dir       <= 1'b0;
         busy      <= 1'b0;
         at_target <= 1'b0;
         cur_pos   <= '0;
      end else begin
         step      <= (next_state == ST_STEP_HI);
         dir       <= next_dir;
         busy      <= (next_state != ST_IDLE);
         at_target <= (next_state == ST_IDLE) && (next_pos == target_pos);
         cur_pos   <= next_pos;
      end
   end

endmodule

// File: tb/tb_stepper_position_ctrl.sv
// Directed bench for stepper_position_ctrl with short timing
// (period 10, pulse 3, setup 2); expected cycle positions are hand-derived.
module tb_stepper_position_ctrl;

   localparam int PW = 3;
   localparam int DS = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic               enable = 1'b0;
   logic signed [31:0] target_pos = 32'sd0;
   logic               zero_pos = 1'b0;
   logic               step;
   logic               dir;
   logic               busy;
   logic               at_target;
   logic signed [31:0] cur_pos;

   int tests = 0;
   int failures = 0;

   int   cyc;
   int   rises;
   int   rise_at [32];
   int   hi_run;
   int   hi_bad;
   int   dir_bad;
   int   setup_bad;
   int   dir_chg_cyc;
   logic prev_step;
   logic prev_dir;

   stepper_position_ctrl #(
      .POS_WIDTH   (32),
      .CNT_WIDTH   (20),
      .STEP_PERIOD (10),
      .PULSE_WIDTH (PW),
      .DIR_SETUP   (DS)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .target_pos (target_pos),
      .zero_pos   (zero_pos),
      .step       (step),
      .dir        (dir),
      .busy       (busy),
      .at_target  (at_target),
      .cur_pos    (cur_pos)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic start();
      cyc         = 0;
      rises       = 0;
      hi_run      = 0;
      hi_bad      = 0;
      dir_bad     = 0;
      setup_bad   = 0;
      dir_chg_cyc = -100;
      prev_step   = step;
      prev_dir    = dir;
      for (int k = 0; k < 32; k++) rise_at[k] = -1;
   endtask

   // Advance n cycles, sampling on the falling edge and logging STEP/DIR behaviour
   task automatic watch(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cyc++;
         if (dir !== prev_dir) begin
            dir_chg_cyc = cyc;
            if (step && prev_step) dir_bad++;
         end
         if (step && !prev_step) begin
            if (rises < 32) rise_at[rises] = cyc;
            rises++;
            hi_run = 0;
            if (cyc - dir_chg_cyc < DS) setup_bad++;
         end
         if (step) hi_run++;
         if (!step && prev_step && hi_run != PW) hi_bad++;
         prev_step = step;
         prev_dir  = dir;
      end
   endtask

   task automatic wait_idle(input string tag, input int bound);
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check(tag, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      // Reset state
      @(negedge clk);
      check("rst_step", {31'd0, step}, 32'd0);
      check("rst_dir", {31'd0, dir}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_at_target", {31'd0, at_target}, 32'd0);
      check("rst_cur_pos", cur_pos, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_at_target", {31'd0, at_target}, 32'd1);

      // 1: 0 -> 3
      start();
      enable = 1'b1;
      target_pos = 32'sd3;
      watch(1);
      check("t1_dir", {31'd0, dir}, 32'd1);
      check("t1_busy", {31'd0, busy}, 32'd1);
      check("t1_step_setup", {31'd0, step}, 32'd0);
      watch(31);
      check("t1_busy_late", {31'd0, busy}, 32'd1);
      check("t1_at_target_moving", {31'd0, at_target}, 32'd0);
      watch(1);
      check("t1_rise0", rise_at[0], 32'd3);
      check("t1_rise1", rise_at[1], 32'd13);
      check("t1_rise2", rise_at[2], 32'd23);
      check("t1_rises", rises, 32'd3);
      check("t1_hi_len", hi_bad, 32'd0);
      check("t1_cur_pos", cur_pos, 32'd3);
      check("t1_busy_end", {31'd0, busy}, 32'd0);
      check("t1_at_target", {31'd0, at_target}, 32'd1);

      // 2: 3 -> -2
      start();
      target_pos = -32'sd2;
      watch(1);
      check("t2_dir", {31'd0, dir}, 32'd0);
      watch(51);
      check("t2_busy_late", {31'd0, busy}, 32'd1);
      watch(1);
      check("t2_rise0", rise_at[0], 32'd3);
      check("t2_rise4", rise_at[4], 32'd43);
      check("t2_rises", rises, 32'd5);
      check("t2_setup", setup_bad, 32'd0);
      check("t2_cur_pos", cur_pos, 32'hFFFF_FFFE);
      check("t2_busy_end", {31'd0, busy}, 32'd0);
      check("t2_at_target", {31'd0, at_target}, 32'd1);

      target_pos = 32'sd0;
      wait_idle("home_idle", 100);
      check("home_cur_pos", cur_pos, 32'd0);

      // 3: 0 -> 10, retarget to 0 during the 4th pulse
      start();
      target_pos = 32'sd10;
      watch(34);
      check("t3_step_hi4", {31'd0, step}, 32'd1);
      check("t3_rise3", rise_at[3], 32'd33);
      target_pos = 32'sd0;
      watch(6);
      check("t3_cur_pos4", cur_pos, 32'd4);
      check("t3_dir_held", {31'd0, dir}, 32'd1);
      watch(3);
      check("t3_dir_rev", {31'd0, dir}, 32'd0);
      watch(2);
      check("t3_rise4", rise_at[4], 32'd45);
      watch(40);
      check("t3_rises", rises, 32'd8);
      check("t3_hi_len", hi_bad, 32'd0);
      check("t3_dir_stable", dir_bad, 32'd0);
      check("t3_setup", setup_bad, 32'd0);
      check("t3_cur_pos", cur_pos, 32'd0);
      check("t3_busy_end", {31'd0, busy}, 32'd0);

      // 4: drop enable during the 2nd pulse
      start();
      target_pos = 32'sd5;
      watch(14);
      check("t4_step_hi2", {31'd0, step}, 32'd1);
      enable = 1'b0;
      watch(8);
      check("t4_busy_lo", {31'd0, busy}, 32'd1);
      watch(1);
      check("t4_rises", rises, 32'd2);
      check("t4_hi_len", hi_bad, 32'd0);
      check("t4_cur_pos", cur_pos, 32'd2);
      check("t4_busy_end", {31'd0, busy}, 32'd0);
      check("t4_at_target", {31'd0, at_target}, 32'd0);
      watch(5);
      check("t4_hold_pos", cur_pos, 32'd2);

      // Enable dropped in DIR_SETUP: back to IDLE without a step
      start();
      enable = 1'b1;
      watch(1);
      check("ds_abort_busy", {31'd0, busy}, 32'd1);
      enable = 1'b0;
      watch(1);
      check("ds_abort_idle", {31'd0, busy}, 32'd0);
      watch(4);
      check("ds_abort_rises", rises, 32'd0);
      check("ds_abort_pos", cur_pos, 32'd2);

      // 5: asynchronous reset during STEP_HI
      start();
      enable = 1'b1;
      watch(14);
      check("t5_step_hi", {31'd0, step}, 32'd1);
      check("t5_pos_pre", cur_pos, 32'd3);
      reset = 1'b1;
      #1;
      check("t5_rst_step", {31'd0, step}, 32'd0);
      check("t5_rst_dir", {31'd0, dir}, 32'd0);
      check("t5_rst_busy", {31'd0, busy}, 32'd0);
      check("t5_rst_pos", cur_pos, 32'd0);
      @(negedge clk);
      target_pos = 32'sd1;
      reset = 1'b0;
      start();
      watch(20);
      check("t5_rises", rises, 32'd1);
      check("t5_rise0", rise_at[0], 32'd3);
      check("t5_cur_pos", cur_pos, 32'd1);
      check("t5_at_target", {31'd0, at_target}, 32'd1);

      // 6: zero_pos in IDLE at 7, then ignored during STEP_LO
      target_pos = 32'sd7;
      wait_idle("t6_pre_idle", 150);
      check("t6_pre_pos", cur_pos, 32'd7);
      start();
      zero_pos = 1'b1;
      watch(1);
      zero_pos = 1'b0;
      check("t6_zeroed", cur_pos, 32'd0);
      check("t6_zero_busy", {31'd0, busy}, 32'd0);
      check("t6_zero_at_target", {31'd0, at_target}, 32'd0);
      watch(7);
      check("t6_step_lo", {31'd0, step}, 32'd0);
      zero_pos = 1'b1;
      watch(1);
      zero_pos = 1'b0;
      check("t6_zero_ignored", cur_pos, 32'd1);
      watch(65);
      check("t6_rise0", rise_at[0], 32'd4);
      check("t6_rises", rises, 32'd7);
      check("t6_cur_pos", cur_pos, 32'd7);
      check("t6_busy_end", {31'd0, busy}, 32'd0);
      check("t6_at_target", {31'd0, at_target}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
